// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// funct3 access codes, FSM state encoding and the access legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Flags misalignment, out-of-range words, illegal funct3 and unsigned stores.
    function automatic logic access_err(
        input logic        write,
        input logic [31:0] addr,
        input logic [2:0]  funct3,
        input int unsigned num_words
    );
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = write;
            F3_H:    err = addr[0];
            F3_HU:   err = write | addr[0];
            F3_W:    err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= num_words) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channels between the core and the responder.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: merges store data into the old word and
// extracts/extends load data from it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = old_word[7:0];
        case (lane)
            2'd0: sel_byte = old_word[7:0];
            2'd1: sel_byte = old_word[15:8];
            2'd2: sel_byte = old_word[23:16];
            2'd3: sel_byte = old_word[31:24];
            default: sel_byte = old_word[7:0];
        endcase
        sel_half = lane[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        st_word = old_word;
        ld_data = '0;
        case (funct3)
            F3_B, F3_BU: begin
                case (lane)
                    2'd0: st_word[7:0]   = wdata[7:0];
                    2'd1: st_word[15:8]  = wdata[7:0];
                    2'd2: st_word[23:16] = wdata[7:0];
                    2'd3: st_word[31:24] = wdata[7:0];
                    default: st_word = old_word;
                endcase
                ld_data = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte}
                                           : {24'b0, sel_byte};
            end
            F3_H, F3_HU: begin
                if (lane[1]) begin
                    st_word[31:16] = wdata[15:0];
                end else begin
                    st_word[15:0] = wdata[15:0];
                end
                ld_data = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half}
                                           : {16'b0, sel_half};
            end
            F3_W: begin
                st_word = wdata;
                ld_data = old_word;
            end
            default: begin
                st_word = old_word;
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits
// WAIT_CYCLES, commits to the word array and holds the response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic    clk,
    input logic    rst,
    dmem_if.slave  bus
);

    localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;

    logic [31:0]   mem [NUM_WORDS];

    logic          cur_write;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_f3;
    logic          cur_err;
    logic [AW-1:0] widx;
    logic [31:0]   old_word;
    logic [31:0]   st_word;
    logic [31:0]   ld_data;
    logic          accept;
    logic          commit;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);

    assign accept = (state == IDLE) && bus.req_valid;

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the access is evaluated from the live request rather than the latch.
    always_comb begin
        if (state == IDLE) begin
            cur_write = bus.req_write;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_f3    = bus.req_funct3;
        end else begin
            cur_write = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    always_comb begin
        commit = 1'b0;
        if (state == IDLE) begin
            commit = accept && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            commit = (cnt == '0);
        end
    end

    assign cur_err  = access_err(cur_write, cur_addr, cur_f3, NUM_WORDS);
    assign widx     = cur_addr[AW+1:2];
    assign old_word = mem[widx];

    dmem_lane_align u_align (
        .old_word (old_word),
        .lane     (cur_addr[1:0]),
        .funct3   (cur_f3),
        .wdata    (cur_wdata),
        .st_word  (st_word),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            f3_q          <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        f3_q    <= bus.req_funct3;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                if (!cur_err && cur_write) begin
                    mem[widx] <= st_word;
                end
                bus.rsp_rdata <= (!cur_err && !cur_write) ? ld_data : '0;
                bus.rsp_err   <= cur_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one responder with two wait states and one
// with none, sharing clock and reset.
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_if bus2 ();
    dmem_if bus0 ();

    dmem_responder #(.NUM_WORDS(32), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    dmem_responder #(.NUM_WORDS(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction on the two-wait-state responder with rsp_ready high.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, output logic [31:0] rd,
                          output logic er, output int lat);
        int n;
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_write  = w;
        bus2.req_addr   = a;
        bus2.req_wdata  = d;
        bus2.req_funct3 = f3;
        bus2.rsp_ready  = 1'b1;
        n = 0;
        while (!bus2.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus2.rsp_rdata;
        er = bus2.rsp_err;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.req_funct3 = 3'b000; bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_funct3 = 3'b000; bus0.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, bus2.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus2.rsp_valid}, 32'd0);
        chk("rst_rdata", bus2.rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, bus2.rsp_err}, 32'd0);
        chk("rst0_req_ready", {31'b0, bus0.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Word round trip and latency
        do_req(1'b1, 32'h08, 32'hDEADBEEF, 3'b010, rd, er, lat);
        chk("sw08_lat", lat, 32'd3);
        chk("sw08_err", {31'b0, er}, 32'd0);
        chk("sw08_rdata", rd, 32'h0);
        do_req(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lat);
        chk("lw08_lat", lat, 32'd3);
        chk("lw08_rdata", rd, 32'hDEADBEEF);
        chk("lw08_err", {31'b0, er}, 32'd0);

        // Sub-word accesses
        do_req(1'b1, 32'h10, 32'h11223344, 3'b010, rd, er, lat);
        do_req(1'b1, 32'h11, 32'h000000AA, 3'b000, rd, er, lat);
        chk("sb11_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw10_merged", rd, 32'h1122AA44);
        do_req(1'b0, 32'h11, 32'h0, 3'b000, rd, er, lat);
        chk("lb11", rd, 32'hFFFFFFAA);
        do_req(1'b0, 32'h11, 32'h0, 3'b100, rd, er, lat);
        chk("lbu11", rd, 32'h000000AA);
        do_req(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
        chk("lh12", rd, 32'h00001122);
        do_req(1'b1, 32'h7C, 32'hCAFEF00D, 3'b010, rd, er, lat);
        chk("sw7c_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 32'h7E, 32'h0, 3'b101, rd, er, lat);
        chk("lhu7e", rd, 32'h0000CAFE);
        do_req(1'b0, 32'h7C, 32'h0, 3'b001, rd, er, lat);
        chk("lh7c", rd, 32'hFFFFF00D);
        do_req(1'b1, 32'h12, 32'h00009988, 3'b001, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("sh12_merged", rd, 32'h9988AA44);

        // Error cases
        do_req(1'b1, 32'h00, 32'h55667788, 3'b010, rd, er, lat);
        do_req(1'b0, 32'h06, 32'h0, 3'b010, rd, er, lat);
        chk("lw06_err", {31'b0, er}, 32'd1);
        chk("lw06_rdata", rd, 32'h0);
        do_req(1'b1, 32'h03, 32'h0000FFFF, 3'b001, rd, er, lat);
        chk("sh03_err", {31'b0, er}, 32'd1);
        chk("sh03_lat", lat, 32'd3);
        do_req(1'b1, 32'h01, 32'h000000EE, 3'b100, rd, er, lat);
        chk("sbu01_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 32'h00, 32'h0, 3'b010, rd, er, lat);
        chk("lw00_unchanged", rd, 32'h55667788);
        do_req(1'b0, 32'h80, 32'h0, 3'b010, rd, er, lat);
        chk("lw80_err", {31'b0, er}, 32'd1);
        chk("lw80_rdata", rd, 32'h0);
        do_req(1'b0, 32'h00, 32'h0, 3'b011, rd, er, lat);
        chk("f3_011_err", {31'b0, er}, 32'd1);
        chk("f3_011_rdata", rd, 32'h0);
        do_req(1'b0, 32'h13, 32'h0, 3'b101, rd, er, lat);
        chk("lhu13_err", {31'b0, er}, 32'd1);

        // Backpressure with a held request
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_write  = 1'b0;
        bus2.req_addr   = 32'h08;
        bus2.req_funct3 = 3'b010;
        bus2.rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus2.req_addr = 32'h10;
        n = 0;
        while (!bus2.rsp_valid && n < 50) begin
            chk("bp_wait_req_ready", {31'b0, bus2.req_ready}, 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, bus2.rsp_valid}, 32'd1);
            chk("bp_rdata", bus2.rsp_rdata, 32'hDEADBEEF);
            chk("bp_err", {31'b0, bus2.rsp_err}, 32'd0);
            chk("bp_req_ready", {31'b0, bus2.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_req_ready", {31'b0, bus2.req_ready}, 32'd1);
        chk("bp_hs_rsp_valid", {31'b0, bus2.rsp_valid}, 32'd0);
        chk("bp_hs_rdata", bus2.rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("bp_held_accepted", {31'b0, bus2.req_ready}, 32'd0);
        bus2.req_valid = 1'b0;
        n = 0;
        while (!bus2.rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_held_lat", n, 32'd2);
        chk("bp_held_rdata", bus2.rsp_rdata, 32'h9988AA44);
        @(posedge clk);
        #1;

        // Reset during WAIT drops the pending store
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_write  = 1'b1;
        bus2.req_addr   = 32'h04;
        bus2.req_wdata  = 32'h12345678;
        bus2.req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        chk("mid_in_wait", {31'b0, bus2.req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_req_ready", {31'b0, bus2.req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'b0, bus2.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_no_resp", {31'b0, bus2.rsp_valid}, 32'd0);
        do_req(1'b0, 32'h04, 32'h0, 3'b010, rd, er, lat);
        chk("mid_lw04", rd, 32'h0);
        chk("mid_lw04_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lat);
        chk("mid_lw08_cleared", rd, 32'h0);

        // Zero wait states, back-to-back
        @(negedge clk);
        bus0.req_valid  = 1'b1;
        bus0.req_write  = 1'b1;
        bus0.req_addr   = 32'h00;
        bus0.req_wdata  = 32'h0BADF00D;
        bus0.req_funct3 = 3'b010;
        bus0.rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("w0_sw_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd1);
        chk("w0_sw_req_ready", {31'b0, bus0.req_ready}, 32'd0);
        chk("w0_sw_err", {31'b0, bus0.rsp_err}, 32'd0);
        bus0.req_write = 1'b0;
        @(posedge clk);
        #1;
        chk("w0_hs_req_ready", {31'b0, bus0.req_ready}, 32'd1);
        chk("w0_hs_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        chk("w0_lw_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd1);
        chk("w0_lw_rdata", bus0.rsp_rdata, 32'h0BADF00D);
        chk("w0_lw_err", {31'b0, bus0.rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("w0_done_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
        chk("w0_done_rdata", bus0.rsp_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory load/store interface.
- Accepts one request at a time over a valid/ready handshake and models a configurable number of wait states.
- Performs byte/halfword/word accesses selected by RISC-V funct3, then returns read data and an error flag over a valid/ready response channel.
- Sits between the core's memory stage and a word-organised data array; it is the multi-cycle replacement for the single-cycle data memory.

Parameters:
- NUM_WORDS, 32, depth of the 32-bit word array; byte address range is 0 .. 4*NUM_WORDS-1.
- WAIT_CYCLES, 2, cycles spent in WAIT between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- req_funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts the response
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  output  1  access rejected (misaligned, out of range, illegal funct3)

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst high at a clock edge):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - All array words cleared to 0.
  - Reset overrides every other event, including an in-flight request. A pending store that has not committed is dropped.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch write, addr, wdata and funct3, and evaluate the error condition.
  - Next state is WAIT with counter = WAIT_CYCLES-1; if WAIT_CYCLES == 0, next state is RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; on the cycle the counter is 0, next state is RESP.
- Transition into RESP (single commit edge):
  - Store with no error: write the merged word into the array.
  - Load with no error: register the extracted, extended data into rsp_rdata.
  - rsp_err is registered on the same edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake: next state is IDLE, rsp_valid = 0, rsp_rdata and rsp_err cleared to 0.
  - req_ready stays 0 in RESP, so a request cannot overlap a response.
- Latency: acceptance edge to first rsp_valid-high cycle is WAIT_CYCLES+1 cycles. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Byte order is little-endian. Word index = addr[31:2]; lane = addr[1:0].
- Loads:
  - LB/LBU select byte lane addr[1:0]; LH/LHU select halfword addr[1].
  - Signed forms sign-extend; U forms zero-extend; LW returns the full word.
- Stores: SB updates one byte lane and SH one halfword lane; other lanes are preserved. SW replaces the word.
- Error conditions:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr[31:2] >= NUM_WORDS.
  - funct3 in {011, 110, 111}.
  - Store with funct3 in {100, 101}.
- On error: no array write, rsp_rdata = 0, rsp_err = 1. The response is still delivered through the normal handshake.
- While not in IDLE, request inputs are ignored. The initiator may hold req_valid high; it is accepted only on the next IDLE cycle.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, WAIT, RESP.
  - Error-check function.
- One combinational sub-module, dmem_lane_align:
  - Inputs: old word, addr[1:0], funct3, wdata.
  - Outputs: merged store word and extended load data.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- Word round trip, WAIT_CYCLES=2: SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> rsp_rdata 0xDEADBEEF, rsp_err 0; first rsp_valid exactly 3 cycles after each accept.
- Sub-word: SW 0x10 = 0x11223344; SB 0x11 wdata 0xAA; LW 0x10 -> 0x1122AA44. LB 0x11 -> 0xFFFFFFAA. LBU 0x11 -> 0x000000AA. LH 0x12 -> 0x00001122.
- Errors: LW 0x06 -> err 1, rdata 0. SH 0x03 -> err 1 and the word at 0x00 is unchanged. LW 0x80 with NUM_WORDS=32 -> err 1. funct3 011 -> err 1.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid, rdata and err stable; req_ready 0 throughout; a held req_valid is accepted only the cycle after the handshake.
- Reset mid-operation: rst asserted in WAIT during a SW to 0x04 -> next cycle IDLE with req_ready 1 and rsp_valid 0; LW 0x04 -> 0x00000000.
- WAIT_CYCLES=0: LW accepted -> rsp_valid high the following cycle; back-to-back accepts every 2 cycles with rsp_ready tied high.
